sram_like_bus_arbiter: RTL and testbench
========================================

// Module: sram_like_bus_arbiter
// PURPOSE
//  Shares one sram-like memory port between the core's instruction port (dual-word fetch)
//  and its data port. Sits between the mips_core sram-like outputs and the single
//  sram-like-to-AXI bridge. One transaction is outstanding at a time.
//  Data has priority over instructions; a starvation counter guarantees instruction progress.
//  Each instruction fetch is issued downstream as two sequential word reads, at A and A+4.
// PARAMETERS
//  STARVE_MAX  4  consecutive data grants allowed while inst_req waits; then inst wins
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst            in   1   synchronous active-high reset
//  inst_req       in   1   instruction fetch request; held high until inst_addr_ok
//  inst_addr      in   32  fetch address A; bits[1:0] are ignored (forced to 0)
//  inst_addr_ok   out  1   pulse: fetch accepted
//  inst_data_ok1  out  1   word at A valid on inst_rdata1
//  inst_data_ok2  out  1   word at A+4 valid on inst_rdata2
//  inst_rdata1    out  32  fetched word at A
//  inst_rdata2    out  32  fetched word at A+4
//  data_req       in   1   data request; held high until data_addr_ok
//  data_wr        in   1   1 = write, 0 = read
//  data_size      in   2   0 = byte, 1 = half, 2 = word
//  data_addr      in   32  data address
//  data_wdata     in   32  write data
//  data_addr_ok   out  1   pulse: data request accepted
//  data_data_ok   out  1   pulse: data transaction complete
//  data_rdata     out  32  read data, valid while data_data_ok is high
//  mem_req        out  1   downstream request
//  mem_wr         out  1   downstream write flag
//  mem_size       out  2   downstream size
//  mem_addr       out  32  downstream address
//  mem_wdata      out  32  downstream write data
//  mem_addr_ok    in   1   downstream address accepted
//  mem_data_ok    in   1   downstream response
//  mem_rdata      in   32  downstream read data
// BEHAVIOUR
//  - States: IDLE, D_ADDR, D_DATA, I_ADDR0, I_DATA0, I_ADDR1, I_DATA1.
//  - Reset: state=IDLE, starvation count=0, word buffer=0, all outputs 0.
//    The downstream port shares rst, so no stale response survives a reset.
//  - IDLE grant:
//    - data_req && (!inst_req || cnt<STARVE_MAX) -> grant data, go to D_ADDR.
//    - else if inst_req -> grant inst, go to I_ADDR0.
//    - Grant is combinational in IDLE: the matching *_addr_ok is high that cycle,
//      and the request fields are latched into holding registers.
//  - Starvation count:
//    - +1 (saturating at STARVE_MAX) on each data grant made while inst_req is high.
//    - Cleared on each inst grant.
//    - Unchanged otherwise.
//  - D_ADDR: mem_req=1, mem_* driven from the latched data fields. On mem_addr_ok -> D_DATA.
//  - D_DATA: mem_req=0. On mem_data_ok:
//    - data_data_ok=1, data_rdata=mem_rdata (combinational pass-through).
//    - Go to IDLE. Writes also complete on mem_data_ok.
//  - I_ADDR0: mem_req=1, mem_wr=0, mem_size=2, mem_addr={A[31:2],2'b00}. On mem_addr_ok -> I_DATA0.
//  - I_DATA0: on mem_data_ok, buffer mem_rdata as word0 and go to I_ADDR1.
//  - I_ADDR1: same as I_ADDR0 with mem_addr = A+4 (mod 2^32; 0xFFFFFFFC wraps to 0). On mem_addr_ok -> I_DATA1.
//  - I_DATA1: on mem_data_ok, inst_data_ok1 = inst_data_ok2 = 1 in the same cycle,
//    with inst_rdata1=word0 and inst_rdata2=mem_rdata. Go to IDLE.
//  - mem_req is never high in D_DATA, I_DATA0 or I_DATA1. mem_addr and mem_wdata are
//    stable while mem_req waits for mem_addr_ok.
//  - A new grant is only made in IDLE, so the earliest new accept is the cycle after a
//    data_ok. Back-to-back cost: data = 1 + addr wait + data wait; fetch is roughly twice that.
//  - Simultaneous data_req and inst_req follow the grant rule above. A request that is
//    not granted keeps waiting; its *_addr_ok stays 0.
//  - mem_data_ok outside the D_DATA, I_DATA0 and I_DATA1 states is ignored.
//  - The simulation assertion fires if mem_data_ok arrives while mem_req is waiting.
//  - Reset asserted mid-transaction: IDLE on the next edge, buffers cleared, no *_data_ok issued.
// TESTING
//  - Zero-wait data read 0x1000, mem_rdata=0xDEADBEEF:
//    data_addr_ok at cycle 0, mem_req at cycle 1, data_data_ok with 0xDEADBEEF at cycle 2.
//  - Fetch A=0xBFC00000 with a memory returning addr^0x5A5A5A5A:
//    two downstream reads at 0xBFC00000 and 0xBFC00004.
//    Single beat with rdata1=0xE59A5A5A, rdata2=0xE59A5A5E, both ok flags high.
//  - data_req and inst_req both held high continuously, STARVE_MAX=4:
//    grant order D,D,D,D,I,D,D,D,D,I; inst is never starved.
//  - Fetch at A=0xFFFFFFFC: second downstream address is 0x00000000; the word order is preserved.
//  - Data write 0x12345678 size=2, mem_addr_ok delayed 3 cycles:
//    mem_addr and mem_wdata are stable for all 3 cycles; data_data_ok is issued once.
//  - rst pulsed while in I_DATA0: next cycle IDLE, no inst_data_ok*, the next fetch is issued cleanly.

Source files
------------

// File: rtl/sram_like_bus_arbiter.sv
// Shares one sram-like memory port between the core's instruction port (dual-word fetch) and its
// data port. One downstream transaction is outstanding at a time. Data wins over instructions
// until STARVE_MAX consecutive data grants have been made while an instruction fetch was waiting;
// then the fetch wins. A fetch at A becomes two downstream word reads at A and A+4, returned to
// the core together in a single beat.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request, address A (bits [1:0] ignored)
//   inst_addr_ok                  fetch accepted (combinational in IDLE)
//   inst_data_ok1/2, inst_rdata*  words at A and A+4, presented in the same cycle
//   data_req/wr/size/addr/wdata   data request
//   data_addr_ok, data_data_ok    data accepted / data complete
//   data_rdata                    read data, valid while data_data_ok is high
//   mem_*                         downstream sram-like port toward the AXI bridge
module sram_like_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok1,
  output logic        inst_data_ok2,
  output logic [31:0] inst_rdata1,
  output logic [31:0] inst_rdata2,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StDAddr,
    StDData,
    StIAddr0,
    StIData0,
    StIAddr1,
    StIData1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            d_wr_q, d_wr_d;
  logic [1:0]      d_size_q, d_size_d;
  logic [31:0]     d_addr_q, d_addr_d;
  logic [31:0]     d_wdata_q, d_wdata_d;
  logic [29:0]     i_addr_q, i_addr_d;  // fetch word address A[31:2]
  logic [31:0]     word0_q, word0_d;    // word at A, held until the A+4 word arrives

  logic unused_inst_addr;
  assign unused_inst_addr = ^inst_addr[1:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    d_wr_d        = d_wr_q;
    d_size_d      = d_size_q;
    d_addr_d      = d_addr_q;
    d_wdata_d     = d_wdata_q;
    i_addr_d      = i_addr_q;
    word0_d       = word0_q;
    inst_addr_ok  = 1'b0;
    inst_data_ok1 = 1'b0;
    inst_data_ok2 = 1'b0;
    inst_rdata1   = '0;
    inst_rdata2   = '0;
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_rdata    = '0;
    mem_req       = 1'b0;
    mem_wr        = 1'b0;
    mem_size      = '0;
    mem_addr      = '0;
    mem_wdata     = '0;

    // Outputs stay quiet during reset so nothing is granted or completed on the reset cycle.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (data_req && (!inst_req || cnt_q < StarveMaxC)) begin
            data_addr_ok = 1'b1;
            d_wr_d       = data_wr;
            d_size_d     = data_size;
            d_addr_d     = data_addr;
            d_wdata_d    = data_wdata;
            state_d      = StDAddr;
            // A data grant over a waiting fetch implies cnt_q < STARVE_MAX, so this saturates.
            if (inst_req) cnt_d = cnt_q + CntW'(1);
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            i_addr_d     = inst_addr[31:2];
            cnt_d        = '0;
            state_d      = StIAddr0;
          end
        end
        StDAddr: begin
          mem_req   = 1'b1;
          mem_wr    = d_wr_q;
          mem_size  = d_size_q;
          mem_addr  = d_addr_q;
          mem_wdata = d_wdata_q;
          if (mem_addr_ok) state_d = StDData;
        end
        StDData: begin
          if (mem_data_ok) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
            state_d      = StIdle;
          end
        end
        StIAddr0: begin
          mem_req  = 1'b1;
          mem_size = 2'd2;
          mem_addr = {i_addr_q, 2'b00};
          if (mem_addr_ok) state_d = StIData0;
        end
        StIData0: begin
          if (mem_data_ok) begin
            word0_d = mem_rdata;
            state_d = StIAddr1;
          end
        end
        StIAddr1: begin
          mem_req  = 1'b1;
          mem_size = 2'd2;
          // 30-bit increment wraps 0xFFFFFFFC to 0x00000000.
          mem_addr = {i_addr_q + 30'd1, 2'b00};
          if (mem_addr_ok) state_d = StIData1;
        end
        StIData1: begin
          if (mem_data_ok) begin
            inst_data_ok1 = 1'b1;
            inst_data_ok2 = 1'b1;
            inst_rdata1   = word0_q;
            inst_rdata2   = mem_rdata;
            state_d       = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      d_wr_q    <= 1'b0;
      d_size_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      i_addr_q  <= '0;
      word0_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_wr_q    <= d_wr_d;
      d_size_q  <= d_size_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      i_addr_q  <= i_addr_d;
      word0_q   <= word0_d;
    end
  end

  // A response while the address phase is still pending means the downstream port is broken.
  mem_data_ok_during_req_a : assert property (@(posedge clk) disable iff (rst)
      !(mem_req && mem_data_ok));

endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
module tb_sram_like_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok1, inst_data_ok2;
  logic [31:0] inst_rdata1, inst_rdata2;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  sram_like_bus_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok1(inst_data_ok1),
    .inst_data_ok2(inst_data_ok2),
    .inst_rdata1  (inst_rdata1),
    .inst_rdata2  (inst_rdata2),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;  // cycles after the grant; -1 = not checked
  } mexp_t;

  typedef struct packed {
    logic [31:0] rdata;
    bit          chk;
    int          lat;
  } dexp_t;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
  } iexp_t;

  // Requests still to be presented, and expected responses in arrival order.
  dreq_t       dq[$];
  logic [31:0] iq[$];
  bit          gq[$];  // expected grant order: 0 = data, 1 = inst
  mexp_t       mq[$];
  dexp_t       edq[$];
  iexp_t       eiq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_grant = 0;

  // Memory model knobs.
  int          addr_delay = 0;
  int          data_delay = 0;
  bit          rd_override_en = 1'b0;
  logic [31:0] rd_override = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Requester: present the head of each request queue; the monitor pops on acceptance.
  always begin
    @(posedge clk);
    #1;
    data_req = (dq.size() > 0);
    if (dq.size() > 0) begin
      data_wr    = dq[0].wr;
      data_size  = dq[0].size;
      data_addr  = dq[0].addr;
      data_wdata = dq[0].wdata;
    end
    inst_req = (iq.size() > 0);
    if (iq.size() > 0) inst_addr = iq[0];
  end

  // Downstream memory: optional address-phase wait, then a response after data_delay cycles.
  initial begin
    automatic bit          pend = 1'b0;
    automatic int          wcnt = 0;
    automatic int          dcnt = 0;
    automatic logic [31:0] resp = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
      if (rst) begin
        pend = 1'b0;
        wcnt = 0;
        dcnt = 0;
      end else if (pend) begin
        if (dcnt < data_delay) dcnt++;
        else begin
          mem_data_ok = 1'b1;
          mem_rdata   = resp;
          pend        = 1'b0;
          dcnt        = 0;
        end
      end else if (mem_req) begin
        if (wcnt < addr_delay) wcnt++;
        else begin
          mem_addr_ok = 1'b1;
          wcnt        = 0;
          pend        = 1'b1;
          resp        = mem_wr ? 32'h0 : (rd_override_en ? rd_override : mem_addr ^ 32'h5A5A5A5A);
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    automatic bit          prev_wait = 1'b0;
    automatic logic [31:0] prev_addr = '0;
    automatic logic [31:0] prev_wdata = '0;
    automatic bit          g;
    automatic mexp_t       m;
    automatic dexp_t       d;
    automatic iexp_t       ie;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (data_addr_ok || inst_addr_ok) begin
          t_grant = cyc;
          check32("grant_exclusive", 32'(data_addr_ok & inst_addr_ok), 32'h0);
          if (gq.size() == 0) fail_now("unexpected_grant");
          else begin
            g = gq.pop_front();
            check32("grant_order", 32'(inst_addr_ok), 32'(g));
          end
          if (data_addr_ok && dq.size() > 0) void'(dq.pop_front());
          if (inst_addr_ok && iq.size() > 0) void'(iq.pop_front());
        end
        if (mem_req && prev_wait) begin
          check32("mem_addr_stable", mem_addr, prev_addr);
          check32("mem_wdata_stable", mem_wdata, prev_wdata);
        end
        prev_wait  = mem_req && !mem_addr_ok;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (mem_req && mem_addr_ok) begin
          if (mq.size() == 0) fail_now("unexpected_mem_req");
          else begin
            m = mq.pop_front();
            check32("mem_addr", mem_addr, m.addr);
            check32("mem_wr", 32'(mem_wr), 32'(m.wr));
            check32("mem_size", 32'(mem_size), 32'(m.size));
            if (m.wr) check32("mem_wdata", mem_wdata, m.wdata);
            if (m.lat >= 0) check32("mem_req_latency", 32'(cyc - t_grant), 32'(m.lat));
          end
        end
        if (data_data_ok) begin
          if (edq.size() == 0) fail_now("unexpected_data_data_ok");
          else begin
            d = edq.pop_front();
            if (d.chk) check32("data_rdata", data_rdata, d.rdata);
            if (d.lat >= 0) check32("data_ok_latency", 32'(cyc - t_grant), 32'(d.lat));
          end
        end
        if (inst_data_ok1 || inst_data_ok2) begin
          if (eiq.size() == 0) fail_now("unexpected_inst_data_ok");
          else begin
            ie = eiq.pop_front();
            check32("inst_ok_pair", {30'h0, inst_data_ok1, inst_data_ok2}, 32'h3);
            check32("inst_rdata1", inst_rdata1, ie.r1);
            check32("inst_rdata2", inst_rdata2, ie.r2);
          end
        end
      end
    end
  end

  function automatic bit all_empty();
    return dq.size() == 0 && iq.size() == 0 && gq.size() == 0 && mq.size() == 0 &&
           edq.size() == 0 && eiq.size() == 0;
  endfunction

  task automatic wait_idle(input string name);
    automatic int n = 0;
    while (!all_empty() && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!all_empty()) begin
      fail_now({"timeout_", name});
      dq.delete(); iq.delete(); gq.delete(); mq.delete(); edq.delete(); eiq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] r1, input logic [31:0] r2);
    automatic logic [31:0] base = {a[31:2], 2'b00};
    gq.push_back(1'b1);
    mq.push_back('{wr: 1'b0, size: 2'd2, addr: base, wdata: 32'h0, lat: -1});
    mq.push_back('{wr: 1'b0, size: 2'd2, addr: base + 32'd4, wdata: 32'h0, lat: -1});
    eiq.push_back('{r1: r1, r2: r2});
  endtask

  task automatic push_read(input logic [31:0] a);
    gq.push_back(1'b0);
    mq.push_back('{wr: 1'b0, size: 2'd2, addr: a, wdata: 32'h0, lat: -1});
    edq.push_back('{rdata: a ^ 32'h5A5A5A5A, chk: 1'b1, lat: -1});
  endtask

  initial begin
    automatic int di = 0;
    automatic int n = 0;
    automatic logic [31:0] ia;
    rst = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
    inst_req = 1'b0; inst_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_mem_req", 32'(mem_req), 32'h0);
    check32("rst_data_addr_ok", 32'(data_addr_ok), 32'h0);
    check32("rst_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    check32("rst_data_data_ok", 32'(data_data_ok), 32'h0);
    check32("rst_inst_data_ok", {30'h0, inst_data_ok1, inst_data_ok2}, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait data read.
    rd_override_en = 1'b1;
    rd_override    = 32'hDEADBEEF;
    dq.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h1000, wdata: 32'h0});
    gq.push_back(1'b0);
    mq.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h1000, wdata: 32'h0, lat: 1});
    edq.push_back('{rdata: 32'hDEADBEEF, chk: 1'b1, lat: 2});
    wait_idle("zero_wait_read");
    rd_override_en = 1'b0;

    // Fetch, then fetch across the top of the address space.
    iq.push_back(32'hBFC00000);
    push_fetch(32'hBFC00000, 32'hE59A5A5A, 32'hE59A5A5E);
    wait_idle("fetch_bfc");
    iq.push_back(32'hFFFFFFFC);
    push_fetch(32'hFFFFFFFC, 32'hA5A5A5A6, 32'h5A5A5A5A);
    wait_idle("fetch_wrap");

    // Write with a 3-cycle address-phase stall.
    addr_delay = 3;
    dq.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h2000, wdata: 32'h12345678});
    gq.push_back(1'b0);
    mq.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h2000, wdata: 32'h12345678, lat: 4});
    edq.push_back('{rdata: 32'h0, chk: 1'b0, lat: -1});
    wait_idle("delayed_write");
    addr_delay = 0;

    // Both requesters busy: expect D,D,D,D,I,D,D,D,D,I. Fetch addresses carry junk low bits.
    for (int i = 0; i < 8; i++)
      dq.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h3000 + 32'(4 * i), wdata: 32'h0});
    iq.push_back(32'h00000103);
    iq.push_back(32'h00000202);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) push_fetch(32'h00000103, 32'h5A5A5B5A, 32'h5A5A5B5E);
      else if (k == 9) push_fetch(32'h00000202, 32'h5A5A585A, 32'h5A5A585E);
      else begin
        push_read(32'h3000 + 32'(4 * di));
        di++;
      end
    end
    wait_idle("starvation");

    // Reset while the fetch waits for its first word.
    data_delay = 5;
    iq.push_back(32'h00004000);
    gq.push_back(1'b1);
    mq.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h4000, wdata: 32'h0, lat: -1});
    while (!(mem_req && mem_addr_ok) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("timeout_rst_fetch_issue");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check32("rst_mid_inst_ok", {30'h0, inst_data_ok1, inst_data_ok2}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    data_delay = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32("post_rst_mem_req", 32'(mem_req), 32'h0);
      check32("post_rst_inst_ok", {30'h0, inst_data_ok1, inst_data_ok2}, 32'h0);
    end
    ia = 32'h00005000;
    iq.push_back(ia);
    push_fetch(ia, 32'h5A5A0A5A, 32'h5A5A0A5E);
    wait_idle("fetch_after_rst");

    check32("leftover_expectations",
            32'(dq.size() + iq.size() + gq.size() + mq.size() + edq.size() + eiq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation did not finish");
  end

endmodule
